// File: rtl/cache_data_rsp_buf_if.sv
// cache_data_rsp_buf_if: read-issue and core-response signals of the data response buffer.
interface cache_data_rsp_buf_if #(
  parameter int WORD_W    = 32,
  parameter int TAG_WIDTH = 8,
  parameter int IDX_WIDTH = 2,
  parameter int CNT_W     = 3
);
  logic                 stall_out;
  logic                 read_fire;
  logic [TAG_WIDTH-1:0] read_tag;
  logic [IDX_WIDTH-1:0] read_idx;
  logic [WORD_W-1:0]    read_data;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [WORD_W-1:0]    rsp_data;
  logic [TAG_WIDTH-1:0] rsp_tag;
  logic [IDX_WIDTH-1:0] rsp_idx;
  logic [CNT_W-1:0]     count;
  modport master (
    input  stall_out, rsp_valid, rsp_data, rsp_tag, rsp_idx, count,
    output read_fire, read_tag, read_idx, read_data, rsp_ready
  );
  modport slave (
    output stall_out, rsp_valid, rsp_data, rsp_tag, rsp_idx, count,
    input  read_fire, read_tag, read_idx, read_data, rsp_ready
  );
endinterface

// File: rtl/cache_data_rsp_buf.sv
// cache_data_rsp_buf: pairs issued read tags with next-cycle data-store words and queues them in order.
module cache_data_rsp_buf #(
  parameter int WORD_SIZE = 4,
  parameter int TAG_WIDTH = 8,
  parameter int IDX_WIDTH = 2,
  parameter int DEPTH     = 4
) (
  input logic clk,
  input logic reset,
  cache_data_rsp_buf_if.slave bus
);
  localparam int WORD_W = 8 * WORD_SIZE;
  localparam int AW     = $clog2(DEPTH);
  localparam int CNT_W  = AW + 1;
  localparam int EW     = WORD_W + TAG_WIDTH + IDX_WIDTH;
  logic [EW-1:0]        mem_q [DEPTH];
  logic [AW-1:0]        wr_q, rd_q;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 pend_q;
  logic [TAG_WIDTH-1:0] pend_tag_q;
  logic [IDX_WIDTH-1:0] pend_idx_q;
  logic                 push, pop;
  logic [CNT_W:0]       used;
  assign push = pend_q;
  assign pop  = bus.rsp_valid && bus.rsp_ready;
  // Credits count the pending slot too, so an issued read always finds room next cycle.
  assign used          = {1'b0, count_q} + {{CNT_W{1'b0}}, pend_q};
  assign bus.stall_out = used >= (CNT_W+1)'(DEPTH);
  assign bus.rsp_valid = count_q != '0;
  assign bus.count     = count_q;
  // Gate the unreset storage so the head never shows X while empty.
  assign {bus.rsp_data, bus.rsp_tag, bus.rsp_idx} = bus.rsp_valid ? mem_q[rd_q] : '0;
  always_comb
    count_d = (push && !pop) ? count_q + CNT_W'(1) :
              (!push && pop) ? count_q - CNT_W'(1) : count_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q  <= 1'b0;
      count_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      pend_q  <= bus.read_fire;
      count_q <= count_d;
      wr_q    <= push ? wr_q + AW'(1) : wr_q;
      rd_q    <= pop ? rd_q + AW'(1) : rd_q;
    end
  end
  always_ff @(posedge clk) begin
    if (bus.read_fire) begin
      pend_tag_q <= bus.read_tag;
      pend_idx_q <= bus.read_idx;
    end
    if (push)
      mem_q[wr_q] <= {bus.read_data, pend_tag_q, pend_idx_q};
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(bus.read_fire && bus.stall_out)) else $error("read issued while stall_out high");
      assert (!(push && count_q == CNT_W'(DEPTH))) else $error("push into full response fifo");
    end
  end
endmodule

// File: tb/tb_cache_data_rsp_buf.sv
// tb_cache_data_rsp_buf: directed scoreboard bench for the data response buffer.
module tb_cache_data_rsp_buf;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic reset;
  int compared = 0;
  int mismatched = 0;
  logic [41:0] exp_q [$];
  int m_count;
  logic m_pend;
  logic [31:0] nxt_data;
  int pops;
  always #5 clk = ~clk;
  cache_data_rsp_buf_if #(.WORD_W(32), .TAG_WIDTH(8), .IDX_WIDTH(2), .CNT_W(3)) bus ();
  cache_data_rsp_buf #(.WORD_SIZE(4), .TAG_WIDTH(8), .IDX_WIDTH(2), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_state();
    check("count", 64'(bus.count), 64'(m_count));
    check("rsp_valid", 64'(bus.rsp_valid), 64'(m_count != 0));
    check("stall_out", 64'(bus.stall_out), 64'((m_count + int'(m_pend)) >= DEPTH));
  endtask
  // Called at a negedge: drive one cycle, score any pop, advance the model, land on the next negedge.
  task automatic step(input logic fire, input logic [7:0] tag, input logic [1:0] idx,
                      input logic [31:0] data, input logic ready);
    logic m_pop;
    logic [41:0] e;
    fire = fire && !((m_count + int'(m_pend)) >= DEPTH);
    bus.read_data = nxt_data;
    bus.read_fire = fire;
    bus.read_tag  = tag;
    bus.read_idx  = idx;
    bus.rsp_ready = ready;
    m_pop = (m_count != 0) && ready;
    if (m_pop) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("rsp_data", 64'(bus.rsp_data), 64'(e[41:10]));
        check("rsp_tag", 64'(bus.rsp_tag), 64'(e[9:2]));
        check("rsp_idx", 64'(bus.rsp_idx), 64'(e[1:0]));
        pops++;
      end
    end
    if (fire) exp_q.push_back({data, tag, idx});
    nxt_data = fire ? data : $urandom;
    @(posedge clk);
    m_count = m_count + int'(m_pend) - int'(m_pop);
    m_pend  = fire;
    @(negedge clk);
    check_state();
  endtask
  task automatic do_reset();
    bus.read_fire = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.read_data = $urandom;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_count = 0;
    m_pend = 1'b0;
    exp_q.delete();
    check_state();
    check("rsp_known", 64'($isunknown({bus.rsp_data, bus.rsp_tag, bus.rsp_idx})), 64'(0));
  endtask
  initial begin
    reset = 1'b1;
    bus.read_fire = 1'b0;
    bus.read_tag = '0;
    bus.read_idx = '0;
    bus.read_data = '0;
    bus.rsp_ready = 1'b0;
    nxt_data = '0;
    pops = 0;
    m_count = 0;
    m_pend = 1'b0;
    @(negedge clk);
    do_reset();
    // single read, two-cycle latency
    step(1'b1, 8'h5A, 2'd1, 32'hDEADBEEF, 1'b0);
    check("single_not_yet", 64'(bus.rsp_valid), 64'(0));
    step(1'b0, 8'h00, 2'd0, 32'h0, 1'b0);
    check("single_valid", 64'(bus.rsp_valid), 64'(1));
    check("single_data", 64'(bus.rsp_data), 64'(32'hDEADBEEF));
    check("single_tag", 64'(bus.rsp_tag), 64'(8'h5A));
    step(1'b0, 8'h00, 2'd0, 32'h0, 1'b1);
    check("single_drained", 64'(bus.count), 64'(0));
    // streaming 16 back-to-back reads with the consumer always ready
    pops = 0;
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 2'(i), $urandom, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 2'd0, 32'h0, 1'b1);
    check("stream_pops", 64'(pops), 64'(16));
    check("stream_left", 64'(exp_q.size()), 64'(0));
    // backpressure fills all four slots, then drains in order
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h20 + i), 2'(i), $urandom, 1'b0);
    check("bp_full", 64'(bus.count), 64'(4));
    check("bp_stall", 64'(bus.stall_out), 64'(1));
    check("bp_queued", 64'(exp_q.size()), 64'(4));
    step(1'b0, 8'h00, 2'd0, 32'h0, 1'b1);
    check("bp_stall_drop", 64'(bus.stall_out), 64'(0));
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 2'd0, 32'h0, 1'b1);
    check("bp_drained", 64'(exp_q.size()), 64'(0));
    // simultaneous push and pop at count 3
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h40 + i), 2'd2, $urandom, 1'b0);
    step(1'b1, 8'h43, 2'd3, $urandom, 1'b0);
    check("pp_count3", 64'(bus.count), 64'(3));
    step(1'b0, 8'h00, 2'd0, 32'h0, 1'b1);
    check("pp_count_hold", 64'(bus.count), 64'(3));
    check("pp_head", 64'(bus.rsp_tag), 64'(8'h41));
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 2'd0, 32'h0, 1'b1);
    check("pp_drained", 64'(exp_q.size()), 64'(0));
    // reset with two queued and one pending
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h60 + i), 2'd1, $urandom, 1'b0);
    check("mid_count2", 64'(bus.count), 64'(2));
    do_reset();
    step(1'b1, 8'h77, 2'd3, 32'hCAFEF00D, 1'b0);
    step(1'b0, 8'h00, 2'd0, 32'h0, 1'b0);
    check("post_reset_count", 64'(bus.count), 64'(1));
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 2'd0, 32'h0, 1'b1);
    check("post_reset_empty", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
